// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer that owns the HI/LO registers and signals busy/stall to the hazard unit.
// Optional MADD/MADDU accumulate ops are enabled with `define MDU_MADD_EN.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        result_hi, result_lo;
    logic               commit_ok;

    logic               is_iter;
    logic [CNT_W-1:0]   load_cnt;
    logic [63:0]        calc;
    logic               calc_ok;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa, sb, sq, sr;

    assign sa     = A;
    assign sb     = B;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};

`ifdef MDU_MADD_EN
    assign is_iter = ~md_op[2] | (md_op[2:1] == 2'b11);
`else
    assign is_iter = ~md_op[2];
`endif

    assign stall = busy | (start & is_iter);

    // Result is formed at the start edge; the countdown only models latency.
    always_comb begin
        calc     = 64'b0;
        calc_ok  = 1'b1;
        load_cnt = CNT_W'(MULT_CYCLES);
        sq       = 32'sd0;
        sr       = 32'sd0;
        case (md_op)
            3'b000: calc = prod_s;
            3'b001: calc = prod_u;
            3'b010: begin
                load_cnt = CNT_W'(DIV_CYCLES);
                if (B == 32'b0) begin
                    calc_ok = 1'b0;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    calc = {32'b0, 32'h8000_0000};
                end else begin
                    sq   = sa / sb;
                    sr   = sa % sb;
                    calc = {sr, sq};
                end
            end
            3'b011: begin
                load_cnt = CNT_W'(DIV_CYCLES);
                if (B == 32'b0) calc_ok = 1'b0;
                else            calc = {A % B, A / B};
            end
`ifdef MDU_MADD_EN
            3'b110: calc = {HI, LO} + prod_s;
            3'b111: calc = {HI, LO} + prod_u;
`endif
            default: calc_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            HI        <= 32'b0;
            LO        <= 32'b0;
            result_hi <= 32'b0;
            result_lo <= 32'b0;
            commit_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_iter) begin
                        result_hi <= calc[63:32];
                        result_lo <= calc[31:0];
                        commit_ok <= calc_ok;
                        cnt       <= load_cnt;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else if (start && md_op == 3'b100) begin
                        HI <= A;
                    end else if (start && md_op == 3'b101) begin
                        LO <= A;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (commit_ok) begin
                            HI <= result_hi;
                            LO <= result_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: an arithmetic reference model queues expected post-edge state, a monitor checks it.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, stall;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    typedef struct { logic busy; logic [31:0] hi; logic [31:0] lo; } exp_t;
    exp_t exp_q[$];

    // Reference model state: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi = 0, m_lo = 0;
    int          m_rem = 0;
    logic [63:0] m_pend = 0;
    bit          m_ok = 0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    function automatic bit iter_op(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return (op <= 3'd3) || (op >= 3'd6);
`else
        return op <= 3'd3;
`endif
    endfunction

    task automatic model_step(input bit rst, input bit st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        int          sa, sb, q, r;
        longint      ps;
        logic [63:0] pu;
        exp_t        e;
        sa = a; sb = b;
        ps = longint'(sa) * longint'(sb);
        pu = 64'(a) * 64'(b);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            if (m_rem == 1 && m_ok) {m_hi, m_lo} = m_pend;
            m_rem--;
        end else if (st) begin
            m_ok = 1;
            case (op)
                3'd0: begin m_pend = ps; m_rem = MC; end
                3'd1: begin m_pend = pu; m_rem = MC; end
                3'd2: begin
                    m_rem = DC;
                    if (b == 0) m_ok = 0;
                    else begin
                        if (sa == int'(32'h8000_0000) && sb == -1) begin q = sa; r = 0; end
                        else begin q = sa / sb; r = sa % sb; end
                        m_pend = {r, q};
                    end
                end
                3'd3: begin
                    m_rem = DC;
                    if (b == 0) m_ok = 0;
                    else m_pend = {a % b, a / b};
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
`ifdef MDU_MADD_EN
                3'd6: begin m_pend = {m_hi, m_lo} + 64'(ps); m_rem = MC; end
                3'd7: begin m_pend = {m_hi, m_lo} + pu; m_rem = MC; end
`endif
                default: ;
            endcase
        end
        e.busy = (m_rem > 0); e.hi = m_hi; e.lo = m_lo;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive away from the edge, check stall, queue the expected post-edge state.
    task automatic cyc(input bit rst, input bit st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        bit exp_stall;
        @(negedge clk);
        reset = rst; start = st; md_op = op; A = a; B = b;
        #1;
        exp_stall = (m_rem > 0) || (st && iter_op(op));
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL stall op=%0d got=%b exp=%b", op, stall, exp_stall);
        end
        model_step(rst, st, op, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 32'h0, 32'h0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (busy !== e.busy || HI !== e.hi || LO !== e.lo) begin
                errors++;
                $display("FAIL state got busy=%b HI=%h LO=%h exp busy=%b HI=%h LO=%h",
                         busy, HI, LO, e.busy, e.hi, e.lo);
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        reset = 1; start = 0; md_op = 0; A = 0; B = 0;
        cyc(1, 0, 3'd0, 0, 0);
        cyc(1, 0, 3'd0, 0, 0);
        idle(1);
        cyc(0, 1, 3'd0, 32'hFFFF_FFFE, 32'd3); idle(MC + 1);   // MULT -2*3
        cyc(0, 1, 3'd1, 32'hFFFF_FFFE, 32'd3); idle(MC + 1);   // MULTU
        cyc(0, 1, 3'd2, 32'hFFFF_FFF9, 32'd2); idle(DC + 1);   // DIV -7/2
        cyc(0, 1, 3'd3, 32'd7, 32'd2);         idle(DC + 1);   // DIVU 7/2
        cyc(0, 1, 3'd0, 32'hFFFF_FFFE, 32'd3); idle(MC + 1);
        cyc(0, 1, 3'd2, 32'd5, 32'd0);         idle(DC + 1);   // divide by zero
        cyc(0, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(DC + 1);
        cyc(0, 1, 3'd2, 32'd100, 32'd7); idle(2);
        cyc(0, 1, 3'd4, 32'h1234, 0);                          // MTHI while busy
        cyc(0, 1, 3'd0, 32'd9, 32'd9);                         // MULT while busy
        idle(DC);
        cyc(0, 1, 3'd4, 32'h1234, 0); idle(2);
        cyc(0, 1, 3'd0, 32'd11, 32'd13); idle(1);
        cyc(1, 0, 3'd0, 0, 0); idle(MC + 3);                   // reset mid-MULT
        cyc(0, 1, 3'd6, 32'd4, 32'd4); idle(2);                // reserved or MADD
        cyc(0, 1, 3'd7, 32'd4, 32'd4); idle(MC + 1);
`ifdef MDU_MADD_EN
        cyc(0, 1, 3'd4, 32'h0, 0);
        cyc(0, 1, 3'd5, 32'hFFFF_FFFF, 0);
        cyc(0, 1, 3'd7, 32'd1, 32'd1); idle(MC + 1);
`endif
        for (int i = 0; i < 600; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 9);
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                3'($urandom_range(0, 7)), ra, rb);
        end
        idle(DC + 2);
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
